// File: rtl/dac_axis_sample_player.sv
// rtl/dac_axis_sample_player.sv - AXI-Stream sample FIFO and packet player for the FMC150 DAC path
//
// Ports:
//   clk_245_76MHz   sole clock (DAC domain)
//   cpu_reset       synchronous active-high reset
//   s_axis_tdata    {i0,q0,i1,q1}, 16 bits each
//   s_axis_tkeep    tkeep[3:0]==0 marks the lower pair (i1/q1) invalid
//   s_axis_tvalid   word valid
//   s_axis_tlast    last word of a packet
//   s_axis_tready   registered !full
//   play_enable     level, arms playback
//   flush           one-cycle pulse, empties the FIFO and returns to IDLE
//   dac_data_i/q    registered I/Q sample
//   dac_data_valid  sample presented this cycle
//   packet_done     one-cycle pulse the cycle after the last sample of a packet
//   underrun        sticky underrun flag, cleared by reset or flush
//   underrun_count  saturating underrun event count
//   sample_count    samples output in the current packet

module dac_axis_sample_player #(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int PRIME_THRESH    = 4
) (
    input  logic                        clk_245_76MHz,
    input  logic                        cpu_reset,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    input  logic                        play_enable,
    input  logic                        flush,
    output logic [15:0]                 dac_data_i,
    output logic [15:0]                 dac_data_q,
    output logic                        dac_data_valid,
    output logic                        packet_done,
    output logic                        underrun,
    output logic [15:0]                 underrun_count,
    output logic [31:0]                 sample_count
);

    localparam int DW    = AXI_DATA_WIDTH;
    localparam int EW    = DW + 2;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    state_t state, state_next;

    // FIFO entry layout: {tlast, half_valid, tdata}
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count, count_next;
    logic [CW-1:0] tlast_count, tlast_next;
    logic          tready_q;
    logic          push;
    logic          in_half_valid;
    logic          unused_tkeep_hi;

    logic [EW-1:0] head;
    logic          head_last;
    logic          head_half_valid;
    logic          fifo_empty;

    // Which pair of the head word is next: 0 = upper (i0/q0), 1 = lower (i1/q1)
    logic          half_sel;
    logic          pkt_start;
    logic          last_out;

    logic          emit;
    logic          pop;
    logic          pkt_end;
    logic          underrun_evt;
    logic [15:0]   sample_i, sample_q;

    assign in_half_valid   = (s_axis_tkeep[3:0] != 4'h0);
    assign unused_tkeep_hi = ^s_axis_tkeep[DW/8-1:4];
    assign push            = s_axis_tvalid && tready_q;
    assign s_axis_tready   = tready_q;

    assign head            = fifo_mem[rd_ptr];
    assign head_last       = head[EW-1];
    assign head_half_valid = head[EW-2];
    assign fifo_empty      = (fifo_count == '0);

    assign count_next = fifo_count + CW'(push) - CW'(pop);
    assign tlast_next = tlast_count + CW'(push && s_axis_tlast) - CW'(pop && head_last);

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_245_76MHz) begin
        if (push && !flush && !cpu_reset) begin
            fifo_mem[wr_ptr] <= {s_axis_tlast, in_half_valid, s_axis_tdata};
        end
    end

    always_ff @(posedge clk_245_76MHz) begin
        if (cpu_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            tlast_count <= '0;
            tready_q    <= 1'b0;
        end else if (flush) begin
            // A word pushed in the flush cycle is dropped.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            tlast_count <= '0;
            tready_q    <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count  <= count_next;
            tlast_count <= tlast_next;
            // Registered from the next count so tready never depends on tvalid.
            tready_q    <= (count_next != CW'(DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_245_76MHz) begin
        if (cpu_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play_enable) begin
                        state_next = ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (!play_enable) begin
                        state_next = ST_IDLE;
                    end else if (fifo_count >= CW'(PRIME_THRESH) || tlast_count != '0) begin
                        state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!play_enable) begin
                        state_next = ST_IDLE;
                    end else if (underrun_evt || pkt_end) begin
                        state_next = ST_PRIME;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (sample select, pop, packet end, underrun event)
    // ------------------------------------------------------------------
    always_comb begin
        emit         = 1'b0;
        pop          = 1'b0;
        pkt_end      = 1'b0;
        underrun_evt = 1'b0;
        sample_i     = 16'h0000;
        sample_q     = 16'h0000;
        if (state == ST_PLAY && !flush) begin
            if (!play_enable) begin
                // Leaving mid-word discards the rest of that word.
                pop = half_sel;
            end else if (fifo_empty) begin
                // The head word stays queued until its last pair is out, so an
                // empty FIFO here always means we are at a word boundary.
                underrun_evt = 1'b1;
            end else begin
                emit = 1'b1;
                if (half_sel) begin
                    sample_i = head[31:16];
                    sample_q = head[15:0];
                end else begin
                    sample_i = head[DW-1 -: 16];
                    sample_q = head[DW-17 -: 16];
                end
                pop     = half_sel || !head_half_valid;
                pkt_end = pop && head_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Playback datapath and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk_245_76MHz) begin
        if (cpu_reset) begin
            half_sel       <= 1'b0;
            pkt_start      <= 1'b0;
            last_out       <= 1'b0;
            dac_data_i     <= 16'h0000;
            dac_data_q     <= 16'h0000;
            dac_data_valid <= 1'b0;
            packet_done    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= 16'h0000;
            sample_count   <= 32'h0000_0000;
        end else if (flush) begin
            half_sel       <= 1'b0;
            last_out       <= 1'b0;
            dac_data_i     <= 16'h0000;
            dac_data_q     <= 16'h0000;
            dac_data_valid <= 1'b0;
            packet_done    <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            if (pop) begin
                half_sel <= 1'b0;
            end else if (emit) begin
                half_sel <= 1'b1;
            end

            dac_data_valid <= emit;
            dac_data_i     <= sample_i;
            dac_data_q     <= sample_q;

            // packet_done trails the last sample by one cycle.
            last_out    <= pkt_end;
            packet_done <= last_out;

            if (underrun_evt) begin
                underrun <= 1'b1;
                if (underrun_count != 16'hFFFF) begin
                    underrun_count <= underrun_count + 16'd1;
                end
            end

            // The count of a finished packet stays visible until the next
            // packet's first sample restarts it at 1.
            if (state == ST_IDLE && state_next == ST_PRIME) begin
                sample_count <= 32'h0000_0000;
                pkt_start    <= 1'b0;
            end else if (emit) begin
                sample_count <= pkt_start ? 32'd1 : sample_count + 32'd1;
                pkt_start    <= pkt_end;
            end
        end
    end

endmodule

// File: tb/tb_dac_axis_sample_player.sv
// tb/tb_dac_axis_sample_player.sv - self-checking bench for dac_axis_sample_player
`timescale 1ns/1ps

module tb_dac_axis_sample_player;

    logic        clk_245_76MHz = 1'b0;
    logic        cpu_reset     = 1'b1;
    logic [63:0] s_axis_tdata  = '0;
    logic [7:0]  s_axis_tkeep  = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast  = 1'b0;
    logic        s_axis_tready;
    logic        play_enable   = 1'b0;
    logic        flush         = 1'b0;
    logic [15:0] dac_data_i;
    logic [15:0] dac_data_q;
    logic        dac_data_valid;
    logic        packet_done;
    logic        underrun;
    logic [15:0] underrun_count;
    logic [31:0] sample_count;

    dac_axis_sample_player #(
        .AXI_DATA_WIDTH (64),
        .FIFO_DEPTH_LOG2(4),
        .PRIME_THRESH   (4)
    ) dut (
        .clk_245_76MHz (clk_245_76MHz),
        .cpu_reset     (cpu_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .play_enable   (play_enable),
        .flush         (flush),
        .dac_data_i    (dac_data_i),
        .dac_data_q    (dac_data_q),
        .dac_data_valid(dac_data_valid),
        .packet_done   (packet_done),
        .underrun      (underrun),
        .underrun_count(underrun_count),
        .sample_count  (sample_count)
    );

    always #2 clk_245_76MHz = ~clk_245_76MHz;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the expected stream of played samples.
    typedef struct {
        logic [31:0] iq;
        bit          last;
        int          pkt_len;
    } exp_t;

    exp_t exp_q[$];
    int   cur_pkt_len = 0;

    function automatic void model_push(input logic [63:0] d, input logic [7:0] k, input bit l);
        exp_t e;
        bit   both;
        both = (k[3:0] != 4'h0);
        cur_pkt_len += both ? 2 : 1;
        e.iq      = d[63:32];
        e.last    = l && !both;
        e.pkt_len = cur_pkt_len;
        exp_q.push_back(e);
        if (both) begin
            e.iq   = d[31:0];
            e.last = l;
            exp_q.push_back(e);
        end
        if (l) cur_pkt_len = 0;
    endfunction

    // Monitor
    bit   mon_en   = 1'b0;
    bit   done_due = 1'b0;
    int   n_done   = 0;
    int   cyc      = 0;
    int   first_v  = -1;
    int   last_v   = -1;
    exp_t mon_e;

    always @(negedge clk_245_76MHz) begin
        cyc++;
        if (mon_en) begin
            if (packet_done || done_due) check_eq("packet_done", packet_done, done_due);
            if (packet_done) n_done++;
            done_due = 1'b0;
            if (dac_data_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("extra_sample", {dac_data_i, dac_data_q}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("sample", {dac_data_i, dac_data_q}, mon_e.iq);
                    if (mon_e.last) begin
                        done_due = 1'b1;
                        check_eq("pkt_sample_count", sample_count, mon_e.pkt_len);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge after acceptance.
    task automatic push_word(input logic [63:0] d, input logic [7:0] k, input bit l);
        bit rdy;
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        do begin
            rdy = s_axis_tready;
            @(negedge clk_245_76MHz);
            n++;
        end while (!rdy && n < 300);
        s_axis_tvalid = 1'b0;
        if (rdy) model_push(d, k, l);
        else check_eq("push_timeout", 0, 1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_245_76MHz);
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
        repeat (3) @(negedge clk_245_76MHz);
    endtask

    task automatic wait_valid_n(input string tag, input int cnt, input int budget);
        int n;
        int seen;
        n = 0;
        seen = 0;
        while (seen < cnt && n < budget) begin
            @(negedge clk_245_76MHz);
            n++;
            if (dac_data_valid) seen++;
        end
        if (seen < cnt) check_eq(tag, seen, cnt);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    logic [63:0] w [8];
    logic [7:0]  kk;
    int          acc;
    int          nv;
    int          n;
    int          plen;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_245_76MHz);
        check_eq("rst_tready", s_axis_tready, 0);
        check_eq("rst_valid", dac_data_valid, 0);
        check_eq("rst_data", {dac_data_i, dac_data_q}, 0);
        check_eq("rst_done", packet_done, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_ucount", underrun_count, 0);
        check_eq("rst_scount", sample_count, 0);
        cpu_reset = 1'b0;
        repeat (2) @(negedge clk_245_76MHz);
        check_eq("post_rst_tready", s_axis_tready, 1);
        mon_en = 1'b1;

        // 4 full words, tlast on the 4th: 8 contiguous samples
        for (int i = 0; i < 4; i++) push_word(rnd64(), 8'hFF, i == 3);
        first_v = -1;
        play_enable = 1'b1;
        drain("t1_drain", 200);
        check_eq("t1_contig", last_v - first_v, 7);
        check_eq("t1_scount", sample_count, 8);
        check_eq("t1_ndone", n_done, 1);

        // Half-valid tlast word
        push_word(rnd64(), 8'hFF, 1'b0);
        push_word(rnd64(), 8'hF0, 1'b1);
        drain("t2_drain", 200);
        check_eq("t2_odd", sample_count[0], 1);
        check_eq("t2_ndone", n_done, 2);

        // Underrun after 4 untermintated words, then resume
        for (int i = 0; i < 4; i++) push_word(rnd64(), 8'hFF, 1'b0);
        n = 0;
        while (!underrun && n < 100) begin
            @(negedge clk_245_76MHz);
            n++;
        end
        check_eq("t3_underrun", underrun, 1);
        check_eq("t3_ucount", underrun_count, 1);
        check_eq("t3_valid", dac_data_valid, 0);
        check_eq("t3_played", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) push_word(rnd64(), 8'hFF, i == 3);
        drain("t3_drain", 200);
        check_eq("t3_ucount2", underrun_count, 1);
        check_eq("t3_scount", sample_count, 16);
        check_eq("t3_ndone", n_done, 3);

        // Fill with playback disabled, then flush
        mon_en = 1'b0;
        play_enable = 1'b0;
        repeat (2) @(negedge clk_245_76MHz);
        acc = 0;
        s_axis_tdata  = rnd64();
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (30) begin
            if (s_axis_tready) acc++;
            @(negedge clk_245_76MHz);
        end
        s_axis_tvalid = 1'b0;
        check_eq("t4_accepted", acc, 16);
        check_eq("t4_full_tready", s_axis_tready, 0);
        flush = 1'b1;
        @(negedge clk_245_76MHz);
        flush = 1'b0;
        n = 1;
        while (!s_axis_tready && n < 2) begin
            @(negedge clk_245_76MHz);
            n++;
        end
        check_eq("t4_flush_tready", s_axis_tready, 1);
        check_eq("t4_underrun_clr", underrun, 0);
        play_enable = 1'b1;
        nv = 0;
        repeat (20) begin
            @(negedge clk_245_76MHz);
            if (dac_data_valid) nv++;
        end
        check_eq("t4_empty_after_flush", nv, 0);

        // Disable mid-packet, re-enable at next word boundary
        play_enable = 1'b0;
        repeat (2) @(negedge clk_245_76MHz);
        for (int i = 0; i < 6; i++) begin
            w[i] = rnd64();
            push_word(w[i], 8'hFF, i == 5);
        end
        play_enable = 1'b1;
        wait_valid_n("t5_first3", 3, 50);
        check_eq("t5_sample3", {dac_data_i, dac_data_q}, w[1][63:32]);
        play_enable = 1'b0;
        @(negedge clk_245_76MHz);
        check_eq("t5_valid_off", dac_data_valid, 0);
        nv = 0;
        repeat (4) begin
            @(negedge clk_245_76MHz);
            if (dac_data_valid || dac_data_i != 0) nv++;
        end
        check_eq("t5_idle_quiet", nv, 0);
        play_enable = 1'b1;
        wait_valid_n("t5_resume", 1, 50);
        check_eq("t5_resume_word", {dac_data_i, dac_data_q}, w[2][63:32]);
        n = 0;
        while (!packet_done && n < 50) begin
            @(negedge clk_245_76MHz);
            n++;
        end
        check_eq("t5_done", packet_done, 1);
        check_eq("t5_scount", sample_count, 8);
        exp_q.delete();
        cur_pkt_len = 0;

        // Reset mid-play
        for (int i = 0; i < 8; i++) push_word(rnd64(), 8'hFF, i == 7);
        wait_valid_n("t6_play", 3, 50);
        cpu_reset = 1'b1;
        @(negedge clk_245_76MHz);
        check_eq("t6_rst_valid", dac_data_valid, 0);
        check_eq("t6_rst_data", {dac_data_i, dac_data_q}, 0);
        check_eq("t6_rst_tready", s_axis_tready, 0);
        check_eq("t6_rst_scount", sample_count, 0);
        repeat (2) @(negedge clk_245_76MHz);
        cpu_reset = 1'b0;
        repeat (2) @(negedge clk_245_76MHz);
        check_eq("t6_ucount", underrun_count, 0);
        check_eq("t6_tready", s_axis_tready, 1);
        nv = 0;
        repeat (20) begin
            @(negedge clk_245_76MHz);
            if (dac_data_valid) nv++;
        end
        check_eq("t6_fifo_empty", nv, 0);
        exp_q.delete();
        cur_pkt_len = 0;

        // Randomized packets against the model
        n_done = 0;
        done_due = 1'b0;
        mon_en = 1'b1;
        for (int p = 0; p < 25; p++) begin
            plen = $urandom_range(1, 10);
            for (int i = 0; i < plen; i++) begin
                kk = $urandom;
                if ($urandom_range(0, 3) == 0) kk[3:0] = 4'h0;
                push_word(rnd64(), kk, i == plen - 1);
                repeat ($urandom_range(0, 2)) @(negedge clk_245_76MHz);
            end
        end
        drain("rnd_drain", 3000);
        check_eq("rnd_ndone", n_done, 25);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
